// File: rtl/music_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// music_ctrl_pkg
//   Shared definitions for the music playback controller:
//   - ASCII key codes that the keyboard delivers (upper and lower case)
//   - cmd_e : decoded playback command, produced by key_decoder and
//             consumed by the music_controller state flops
// -----------------------------------------------------------------------------
package music_ctrl_pkg;

  localparam logic [7:0] KEY_E_UP = 8'h45;
  localparam logic [7:0] KEY_E_LO = 8'h65;
  localparam logic [7:0] KEY_D_UP = 8'h44;
  localparam logic [7:0] KEY_D_LO = 8'h64;
  localparam logic [7:0] KEY_F_UP = 8'h46;
  localparam logic [7:0] KEY_F_LO = 8'h66;
  localparam logic [7:0] KEY_B_UP = 8'h42;
  localparam logic [7:0] KEY_B_LO = 8'h62;
  localparam logic [7:0] KEY_R_UP = 8'h52;
  localparam logic [7:0] KEY_R_LO = 8'h72;

  typedef enum logic [2:0] {
    CMD_NONE    = 3'd0,
    CMD_PLAY    = 3'd1,
    CMD_PAUSE   = 3'd2,
    CMD_FWD     = 3'd3,
    CMD_BWD     = 3'd4,
    CMD_RESTART = 3'd5
  } cmd_e;

endpackage : music_ctrl_pkg

// File: rtl/key_decoder.sv
// -----------------------------------------------------------------------------
// key_decoder
//   Purely combinational map from a keyboard ASCII code to a playback command.
//   Both letter cases decode to the same command; any code while the
//   keyboard is not presenting valid data, and any unrecognised code,
//   decodes to CMD_NONE.
//
// Ports
//   keyboard_input   in  [7:0]  ASCII code of the current key
//   kybrd_data_ready in         keyboard_input valid this cycle
//   cmd              out cmd_e  decoded command
// -----------------------------------------------------------------------------
module key_decoder
  import music_ctrl_pkg::*;
(
  input  logic [7:0] keyboard_input,
  input  logic       kybrd_data_ready,
  output cmd_e       cmd
);

  always_comb begin
    cmd = CMD_NONE;
    if (kybrd_data_ready) begin
      case (keyboard_input)
        KEY_E_UP, KEY_E_LO: cmd = CMD_PLAY;
        KEY_D_UP, KEY_D_LO: cmd = CMD_PAUSE;
        KEY_F_UP, KEY_F_LO: cmd = CMD_FWD;
        KEY_B_UP, KEY_B_LO: cmd = CMD_BWD;
        KEY_R_UP, KEY_R_LO: cmd = CMD_RESTART;
        default:            cmd = CMD_NONE;
      endcase
    end
  end

endmodule : key_decoder

// File: rtl/music_controller.sv
// -----------------------------------------------------------------------------
// music_controller
//   Keyboard-driven playback control. Each cycle with valid keyboard data the
//   decoded command updates the playback state one clock later. pause and
//   forward are independent sticky bits; restart is a one-cycle pulse per
//   sampled 'R'/'r' (a held key re-pulses every cycle it is sampled).
//   All outputs come straight from flops.
//
// Ports
//   clk              in         system clock (rising edge)
//   keyboard_input   in  [7:0]  ASCII code of the current key
//   forward          out        1 = play forward, 0 = backward
//   pause            out        1 = paused, 0 = playing
//   restart          out        single-cycle return-to-start command
//   kybrd_data_ready in         keyboard_input valid this cycle
//   reset_n          in         asynchronous active-low reset
// -----------------------------------------------------------------------------
module music_controller
  import music_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic [7:0] keyboard_input,
  output logic       forward,
  output logic       pause,
  output logic       restart,
  input  logic       kybrd_data_ready,
  input  logic       reset_n
);

  cmd_e cmd;

  logic pause_d,   pause_q;
  logic forward_d, forward_q;
  logic restart_d, restart_q;

  key_decoder u_key_decoder (
    .keyboard_input   (keyboard_input),
    .kybrd_data_ready (kybrd_data_ready),
    .cmd              (cmd)
  );

  always_comb begin
    pause_d   = pause_q;
    forward_d = forward_q;
    // restart is a pulse: it falls unless re-armed by a sampled restart key.
    restart_d = 1'b0;
    case (cmd)
      CMD_PLAY:    pause_d   = 1'b0;
      CMD_PAUSE:   pause_d   = 1'b1;
      CMD_FWD:     forward_d = 1'b1;
      CMD_BWD:     forward_d = 1'b0;
      CMD_RESTART: restart_d = 1'b1;
      default:     ;
    endcase
  end

  // Reset leaves playback paused, pointing forward, with no restart pending.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pause_q   <= 1'b1;
      forward_q <= 1'b1;
      restart_q <= 1'b0;
    end else begin
      pause_q   <= pause_d;
      forward_q <= forward_d;
      restart_q <= restart_d;
    end
  end

  assign pause   = pause_q;
  assign forward = forward_q;
  assign restart = restart_q;

endmodule : music_controller

// File: tb/tb_music_controller.sv
// -----------------------------------------------------------------------------
// tb_music_controller
//   Scoreboard bench: each driven cycle pushes the expected output triple to
//   a queue; after the sampling edge the triple is popped and compared.
// -----------------------------------------------------------------------------
module tb_music_controller;

  typedef struct packed {
    logic pause;
    logic fwd;
    logic rst;
  } exp_t;

  logic       clk;
  logic [7:0] keyboard_input;
  logic       kybrd_data_ready;
  logic       reset_n;
  logic       forward;
  logic       pause;
  logic       restart;

  int tests_run;
  int tests_failed;

  exp_t exp_q[$];

  // reference state
  logic m_pause;
  logic m_fwd;
  logic m_rst;

  music_controller dut (
    .clk              (clk),
    .keyboard_input   (keyboard_input),
    .forward          (forward),
    .pause            (pause),
    .restart          (restart),
    .kybrd_data_ready (kybrd_data_ready),
    .reset_n          (reset_n)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_bit(input string tag, input logic obs, input logic req);
    tests_run++;
    if (obs !== req) begin
      tests_failed++;
      $display("FAIL %s: got %b, expected %b at %0t", tag, obs, req, $time);
    end
  endtask

  // Reference behaviour for one sampled cycle.
  task automatic model_cycle(input logic [7:0] code, input logic rdy);
    m_rst = 1'b0;
    if (rdy) begin
      if (code == 8'h45 || code == 8'h65) m_pause = 1'b0;
      else if (code == 8'h44 || code == 8'h64) m_pause = 1'b1;
      else if (code == 8'h46 || code == 8'h66) m_fwd = 1'b1;
      else if (code == 8'h42 || code == 8'h62) m_fwd = 1'b0;
      else if (code == 8'h52 || code == 8'h72) m_rst = 1'b1;
    end
  endtask

  // Drive one cycle at the falling edge, check just after the rising edge.
  task automatic step(input string tag, input logic [7:0] code, input logic rdy);
    exp_t e;
    @(negedge clk);
    keyboard_input   = code;
    kybrd_data_ready = rdy;
    model_cycle(code, rdy);
    e.pause = m_pause;
    e.fwd   = m_fwd;
    e.rst   = m_rst;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    if (exp_q.size() == 0) begin
      check_bit({tag, "_queue"}, 1'b0, 1'b1);
    end else begin
      e = exp_q.pop_front();
      check_bit({tag, "_pause"},   pause,   e.pause);
      check_bit({tag, "_forward"}, forward, e.fwd);
      check_bit({tag, "_restart"}, restart, e.rst);
    end
  endtask

  task automatic model_reset();
    m_pause = 1'b1;
    m_fwd   = 1'b1;
    m_rst   = 1'b0;
  endtask

  logic [7:0] codes [12];

  initial begin
    tests_run        = 0;
    tests_failed     = 0;
    keyboard_input   = 8'h00;
    kybrd_data_ready = 1'b0;
    reset_n          = 1'b1;
    model_reset();

    // Asynchronous reset asserted mid-cycle, checked before any clock edge.
    #2 reset_n = 1'b0;
    #1;
    check_bit("rst_pause",   pause,   1'b1);
    check_bit("rst_forward", forward, 1'b1);
    check_bit("rst_restart", restart, 1'b0);
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;

    // Basic command sequence
    step("cmd_E", 8'h45, 1'b1);
    step("cmd_D", 8'h44, 1'b1);
    step("cmd_F", 8'h46, 1'b1);
    step("cmd_B", 8'h42, 1'b1);

    // Ready gating: 'E' ignored while not ready (pause stays 1)
    for (int i = 0; i < 4; i++) step("gate_E", 8'h45, 1'b0);

    // Single restart pulse, then idle
    step("rst_once", 8'h52, 1'b1);
    step("rst_idle", 8'h52, 1'b0);
    step("rst_idle2", 8'h00, 1'b0);

    // Held restart for three sampled cycles
    for (int i = 0; i < 3; i++) step("rst_held", 8'h52, 1'b1);
    step("rst_after", 8'h52, 1'b0);

    // Lower case and no-op codes
    step("cmd_e", 8'h65, 1'b1);
    step("cmd_f", 8'h66, 1'b1);
    step("cmd_b", 8'h62, 1'b1);
    step("noop_41", 8'h41, 1'b1);
    step("cmd_r", 8'h72, 1'b1);
    step("cmd_d", 8'h64, 1'b1);
    // Direction change retained while paused
    step("fwd_paused", 8'h46, 1'b1);
    step("noop_C5", 8'hC5, 1'b1);
    step("noop_00", 8'h00, 1'b1);

    // Randomised mix of commands, no-ops and ready gating
    codes[0] = 8'h45; codes[1]  = 8'h65; codes[2]  = 8'h44; codes[3]  = 8'h64;
    codes[4] = 8'h46; codes[5]  = 8'h66; codes[6]  = 8'h42; codes[7]  = 8'h62;
    codes[8] = 8'h52; codes[9]  = 8'h72; codes[10] = 8'h41; codes[11] = 8'hE5;
    for (int i = 0; i < 60; i++) begin
      step("rand", codes[$urandom_range(0, 11)], 1'($urandom_range(0, 3) != 0));
    end

    // Reset while a restart pulse is high
    step("pre_rst_restart", 8'h72, 1'b1);
    check_bit("restart_high", restart, 1'b1);
    #2 reset_n = 1'b0;
    #1;
    model_reset();
    check_bit("midrst_restart", restart, 1'b0);
    check_bit("midrst_pause",   pause,   1'b1);
    check_bit("midrst_forward", forward, 1'b1);
    @(negedge clk);
    kybrd_data_ready = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;

    // Operation resumes normally after reset
    step("post_B", 8'h62, 1'b1);
    step("post_E", 8'h45, 1'b1);
    step("post_idle", 8'h44, 1'b0);

    check_bit("queue_drained", 1'(exp_q.size() == 0), 1'b1);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule : tb_music_controller

// File: doc/music_controller.md
MUSIC_CONTROLLER -- requirements
Module: music_controller

Interface
REQ-001 The block SHALL use a single clock and an asynchronous, active-low reset; all state SHALL be held in flops on the rising edge of clk.
REQ-002 Port clk, input, 1 bit: system clock.
REQ-003 Port reset_n, input, 1 bit: asynchronous active-low reset.
REQ-004 Port keyboard_input, input, 8 bits: ASCII code of the current key.
REQ-005 Port kybrd_data_ready, input, 1 bit: keyboard_input is valid this cycle (level-qualified, no ack).
REQ-006 Port forward, output, 1 bit: playback direction, 1 = forward, 0 = backward.
REQ-007 Port pause, output, 1 bit: 1 = playback paused, 0 = playing.
REQ-008 Port restart, output, 1 bit: single-cycle command to return playback to the start address.
REQ-009 Positional port order SHALL be clk, keyboard_input, forward, pause, restart, kybrd_data_ready, reset_n.

Function
REQ-010 A command SHALL be sampled on every rising clk edge where kybrd_data_ready=1; when kybrd_data_ready=0 the keyboard_input value SHALL be ignored.
REQ-011 Codes 0x45 'E' and 0x65 'e' SHALL clear pause (play).
REQ-012 Codes 0x44 'D' and 0x64 'd' SHALL set pause (stop).
REQ-013 Codes 0x46 'F' and 0x66 'f' SHALL set forward.
REQ-014 Codes 0x42 'B' and 0x62 'b' SHALL clear forward.
REQ-015 Codes 0x52 'R' and 0x72 'r' SHALL drive restart=1 for the cycle after the sampling edge; restart SHALL NOT change pause or forward.
REQ-016 Every other code SHALL be a no-op; outputs SHALL hold their values.
REQ-017 Latency SHALL be one clock: outputs SHALL reflect a sampled command immediately after the sampling edge.
REQ-018 Commands SHALL be level-sensitive, not edge-detected: holding kybrd_data_ready=1 with the same code SHALL re-apply that code every cycle. A held 'R' SHALL therefore keep restart high for each sampled cycle.
REQ-019 restart SHALL be 0 in every cycle that does not follow a sampled 'R'/'r'.
REQ-020 pause and forward SHALL be independent state bits; direction changes while paused SHALL be retained.
REQ-021 All outputs SHALL be driven directly from flops, with no combinational path from the inputs.

Reset
REQ-022 While reset_n=0: pause=1, forward=1, restart=0, applied asynchronously.
REQ-023 The first command SHALL be sampled on the first rising edge with reset_n=1 and kybrd_data_ready=1.
REQ-024 A reset asserted mid-operation SHALL override any pending command, including a restart pulse in progress.

Structure
REQ-025 Package music_ctrl_pkg SHALL hold the ASCII key-code constants and an enumerated command type: CMD_NONE, CMD_PLAY, CMD_PAUSE, CMD_FWD, CMD_BWD, CMD_RESTART.
REQ-026 A sub-module key_decoder SHALL combinationally map keyboard_input and kybrd_data_ready to the command enum, covering both letter cases; music_controller SHALL contain only the state flops.

Verification
REQ-027 Reset: assert reset_n=0 asynchronously mid-cycle -> pause=1, forward=1, restart=0 immediately.
REQ-028 Command sequence with ready=1, one cycle each: 'E','D','F','B' -> after each edge pause=0, then pause=1, then forward=1, then forward=0.
REQ-029 Ready gating: ready=0 with 'E' applied for 4 cycles -> pause and forward unchanged.
REQ-030 Restart: ready=1 with 0x52 for one cycle, then ready=0 -> restart high for exactly one cycle, then 0; pause and forward unchanged. Holding 0x52 with ready=1 for 3 cycles -> restart high for 3 cycles.
REQ-031 Case and no-op handling: 'e' -> pause=0; 'b' -> forward=0; 0x41 -> no output changes.
REQ-032 Reset during restart: assert reset_n=0 in the cycle restart=1 -> restart drops to 0 at once.
